// File: rtl/tb_ram_multiport_if.sv
// Request/response bundle for tb_ram_multiport.
// Vectors are port-major: port p occupies slice [p*W +: W].
interface tb_ram_multiport_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int BW = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS*BW-1:0]         be;
    logic [NUM_PORTS*32-1:0]         addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
    logic [NUM_PORTS-1:0]            ready;
    logic [NUM_PORTS-1:0]            rvalid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/tb_ram_multiport.sv
// Shared-array multi-port memory model with per-port wait states, read-latency pipeline and byte masks.
// Define TB_RAM_COLLISION_CHECK_EN to enable same-word conflict detection and reporting.
module tb_ram_multiport #(
    parameter int    NUM_PORTS    = 2,
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 16384,
    parameter int    READ_LATENCY = 1,
    parameter int    WAIT_CYCLES  = 0,
    parameter string INIT_FILE    = ""
) (
    input  logic              clock,
    input  logic              reset_n,
    tb_ram_multiport_if.slave bus,
    output logic              collision
);
    localparam int         BW        = DATA_WIDTH / 8;
    localparam int         ALSB      = $clog2(BW);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         word_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0]  cnt_zero;
    logic [NUM_PORTS-1:0]  ready_w;
    logic [NUM_PORTS-1:0]  accept;
    logic [NUM_PORTS-1:0]  rd_accept;
    logic                  rv_port [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rd_port [NUM_PORTS];

    // Only the word-index field of each address reaches the array; higher bits wrap away.
    wire unused_addr_bits = ^bus.addr;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ready_w[p]                             = bus.req[p] & cnt_zero[p];
            bus.rvalid[p]                          = rv_port[p];
            bus.rdata[p*DATA_WIDTH +: DATA_WIDTH]  = rd_port[p];
        end
    end

    assign bus.ready = ready_w;
    assign accept    = ready_w;
    assign rd_accept = accept & ~bus.we;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [3:0]              cnt_reg;
            logic [3:0]              cnt_next;
            logic [DATA_WIDTH-1:0]   lane_mask;
            logic [READ_LATENCY-1:0] valid_reg;
            logic [DATA_WIDTH-1:0]   data_reg [READ_LATENCY];

            assign word_idx[gi] = bus.addr[gi*32+ALSB +: AW];
            assign cnt_zero[gi] = (cnt_reg == 4'd0);

            // Idle and accept both reload, so every fresh request pays the full stall.
            always_comb begin
                cnt_next = WAIT_LOAD;
                if (bus.req[gi] && !ready_w[gi]) cnt_next = cnt_reg - 4'd1;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) cnt_reg <= 4'd0;
                else          cnt_reg <= cnt_next;
            end

            always_comb begin
                lane_mask = '0;
                for (int b = 0; b < BW; b++) lane_mask[b*8 +: 8] = {8{bus.be[gi*BW+b]}};
            end

            // Data stages only move with a valid token, so the last stage holds the previous read.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg <= '0;
                    for (int i = 0; i < READ_LATENCY; i++) data_reg[i] <= '0;
                end else begin
                    valid_reg[0] <= rd_accept[gi];
                    if (rd_accept[gi]) data_reg[0] <= mem[word_idx[gi]] & lane_mask;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        valid_reg[i] <= valid_reg[i-1];
                        if (valid_reg[i-1]) data_reg[i] <= data_reg[i-1];
                    end
                end
            end

            assign rv_port[gi] = valid_reg[READ_LATENCY-1];
            assign rd_port[gi] = data_reg[READ_LATENCY-1];
        end
    endgenerate

    // Later ports overwrite earlier ones lane by lane; reads above see the pre-edge contents.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < BW; b++) begin
                if (reset_n && accept[p] && bus.we[p] && bus.be[p*BW+b])
                    mem[word_idx[p]][b*8 +: 8] <= bus.wdata[p*DATA_WIDTH + b*8 +: 8];
            end
        end
    end

`ifdef TB_RAM_COLLISION_CHECK_EN
    logic        hit_next;
    logic        collision_reg;
    logic [31:0] collision_count;

    always_comb begin
        hit_next = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (accept[p] && accept[q] && (word_idx[p] == word_idx[q]) && (bus.we[p] || bus.we[q]))
                    hit_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            collision_reg   <= 1'b0;
            collision_count <= '0;
        end else begin
            collision_reg <= hit_next;
            if (hit_next && (collision_count != '1)) collision_count <= collision_count + 32'd1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int q = p + 1; q < NUM_PORTS; q++) begin
                    if (accept[p] && accept[q] && (word_idx[p] == word_idx[q]) && (bus.we[p] || bus.we[q]))
                        $error("tb_ram_multiport: ports %0d and %0d collide on word %0h at %0t",
                               p, q, word_idx[p], $time);
                end
            end
        end
    end

    assign collision = collision_reg;
`else
    assign collision = 1'b0;
`endif

endmodule
